// File: rtl/snake_head_ctrl_if.sv
// Handshake bundle between the push-button selector/draw logic and the snake head controller.
interface snake_head_ctrl_if;
  logic [4:0] go;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [1:0] dir;
  logic       step;
  logic [1:0] state;
  logic       game_over;

  modport master (output go, input head_x, head_y, dir, step, state, game_over);
  modport slave  (input go, output head_x, head_y, dir, step, state, game_over);
endinterface

// File: rtl/snake_head_ctrl.sv
// Snake head controller: game-state FSM, move-tick divider, heading commit and wall collision.
module snake_head_ctrl #(
  parameter int TICK_DIV = 25_000_000,
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int START_X  = 20,
  parameter int START_Y  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  snake_head_ctrl_if.slave  s_if
);
  localparam int CW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_DEAD = 2'b10} state_t;

  state_t          r_state, w_state_nxt;
  logic [5:0]      r_x, w_x_nxt;
  logic [4:0]      r_y, w_y_nxt;
  logic [1:0]      r_dir, w_dir_nxt;
  logic [1:0]      r_pend, w_pend_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_step, w_step_nxt;
  logic            r_over, w_over_nxt;

  logic       w_any_dir;
  logic [1:0] w_req_dir;
  logic [1:0] w_rev_dir;
  logic       w_tick;
  logic       w_hit;
  logic [5:0] w_cand_x;
  logic [4:0] w_cand_y;

  assign w_any_dir = |s_if.go[3:0];
  assign w_req_dir = s_if.go[0] ? 2'b00 :
                     s_if.go[1] ? 2'b01 :
                     s_if.go[2] ? 2'b10 : 2'b11;
  // Reversal is judged against the committed heading, not the pending one.
  assign w_rev_dir = {r_dir[1], ~r_dir[0]};
  assign w_tick    = (r_cnt == CW'(TICK_DIV - 1));

  always_comb begin
    w_hit    = 1'b0;
    w_cand_x = r_x;
    w_cand_y = r_y;
    case (r_pend)
      2'b00: begin w_hit = (r_y == 5'd0);                w_cand_y = r_y - 5'd1; end
      2'b01: begin w_hit = (r_y == 5'(GRID_H - 1));      w_cand_y = r_y + 5'd1; end
      2'b10: begin w_hit = (r_x == 6'd0);                w_cand_x = r_x - 6'd1; end
      default: begin w_hit = (r_x == 6'(GRID_W - 1));    w_cand_x = r_x + 6'd1; end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_dir_nxt   = r_dir;
    w_pend_nxt  = r_pend;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = 1'b0;
    w_over_nxt  = r_over;
    if (s_if.go[4]) begin
      w_state_nxt = S_IDLE;
      w_x_nxt     = 6'(START_X);
      w_y_nxt     = 5'(START_Y);
      w_dir_nxt   = 2'b11;
      w_pend_nxt  = 2'b11;
      w_cnt_nxt   = '0;
      w_over_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_any_dir && (w_req_dir != w_rev_dir)) w_pend_nxt = w_req_dir;
          if (w_tick) begin
            w_cnt_nxt = '0;
            if (w_hit) begin
              w_state_nxt = S_DEAD;
              w_over_nxt  = 1'b1;
            end else begin
              w_dir_nxt  = r_pend;
              w_x_nxt    = w_cand_x;
              w_y_nxt    = w_cand_y;
              w_step_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_DEAD: ;
        default: begin
          w_cnt_nxt = '0;
          if (w_any_dir) begin
            w_state_nxt = S_RUN;
            w_dir_nxt   = w_req_dir;
            w_pend_nxt  = w_req_dir;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_x     <= 6'(START_X);
      r_y     <= 5'(START_Y);
      r_dir   <= 2'b11;
      r_pend  <= 2'b11;
      r_cnt   <= '0;
      r_step  <= 1'b0;
      r_over  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_dir   <= w_dir_nxt;
      r_pend  <= w_pend_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step_nxt;
      r_over  <= w_over_nxt;
    end
  end

  assign s_if.head_x    = r_x;
  assign s_if.head_y    = r_y;
  assign s_if.dir       = r_dir;
  assign s_if.step      = r_step;
  assign s_if.state     = r_state;
  assign s_if.game_over = r_over;
endmodule

// File: tb/tb_snake_head_ctrl.sv
// Directed bench for snake_head_ctrl with TICK_DIV=4 on an 8x6 grid starting at (4,3).
module tb_snake_head_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  snake_head_ctrl_if bus ();

  snake_head_ctrl #(.TICK_DIV(4), .GRID_W(8), .GRID_H(6), .START_X(4), .START_Y(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_if  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input int x, input int y);
    chk({tag, ".x"}, 8'(bus.head_x), 8'(x));
    chk({tag, ".y"}, 8'(bus.head_y), 8'(y));
  endtask

  task automatic chk_reset(input string tag);
    chk_head(tag, 4, 3);
    chk({tag, ".dir"},   8'(bus.dir),       8'd3);
    chk({tag, ".step"},  8'(bus.step),      8'd0);
    chk({tag, ".state"}, 8'(bus.state),     8'd0);
    chk({tag, ".over"},  8'(bus.game_over), 8'd0);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.go = 5'b00000;
    #1 rst_n = 1'b0;
    cyc(1);
    chk_reset("rst");
    rst_n = 1'b1;
    cyc(1);
    chk_reset("post_rst_idle");

    // Scenario 1: start heading up
    bus.go = 5'b00001; cyc(1);
    chk("s1.state", 8'(bus.state), 8'd1);
    chk("s1.dir",   8'(bus.dir),   8'd0);
    chk_head("s1.enter", 4, 3);
    bus.go = 5'b00000; cyc(3);
    chk("s1.nostep", 8'(bus.step), 8'd0);
    cyc(1);
    chk("s1.step1", 8'(bus.step), 8'd1);
    chk_head("s1.mv1", 4, 2);
    cyc(1);
    chk("s1.step_pulse", 8'(bus.step), 8'd0);
    cyc(3);
    chk("s1.step2", 8'(bus.step), 8'd1);
    chk_head("s1.mv2", 4, 1);

    // Scenario 2: reversal rejected, then turn left
    bus.go = 5'b00010; cyc(4);
    chk("s2.step", 8'(bus.step), 8'd1);
    chk("s2.dir",  8'(bus.dir),  8'd0);
    chk_head("s2.rev", 4, 0);
    bus.go = 5'b00100; cyc(4);
    chk("s2.step_l", 8'(bus.step), 8'd1);
    chk("s2.dir_l",  8'(bus.dir),  8'd2);
    chk_head("s2.left", 3, 0);

    // Scenario 3: restart, run right into the wall
    bus.go = 5'b10000; cyc(1);
    chk_reset("s3.restart");
    bus.go = 5'b01000; cyc(1);
    chk("s3.state", 8'(bus.state), 8'd1);
    chk("s3.dir",   8'(bus.dir),   8'd3);
    bus.go = 5'b00000; cyc(4);
    chk_head("s3.mv1", 5, 3);
    cyc(1);
    chk("s3.pulse", 8'(bus.step), 8'd0);
    cyc(3);
    chk_head("s3.mv2", 6, 3);
    cyc(4);
    chk_head("s3.mv3", 7, 3);
    chk("s3.step3", 8'(bus.step), 8'd1);
    cyc(4);
    chk("s3.hit_step",  8'(bus.step),      8'd0);
    chk("s3.hit_state", 8'(bus.state),     8'd2);
    chk("s3.hit_over",  8'(bus.game_over), 8'd1);
    chk_head("s3.hit", 7, 3);

    // Scenario 4: direction ignored in DEAD, restart leaves
    bus.go = 5'b01000; cyc(20);
    chk("s4.state", 8'(bus.state),     8'd2);
    chk("s4.over",  8'(bus.game_over), 8'd1);
    chk("s4.step",  8'(bus.step),      8'd0);
    chk_head("s4.hold", 7, 3);
    bus.go = 5'b10000; cyc(1);
    chk_reset("s4.restart");

    // Scenario 5: restart coincident with the tick
    bus.go = 5'b00001; cyc(1);
    bus.go = 5'b00000; cyc(3);
    bus.go = 5'b10000; cyc(1);
    chk_reset("s5.restart_tick");

    // Request on the tick cycle is deferred to the following move
    bus.go = 5'b00001; cyc(1);
    bus.go = 5'b00000; cyc(3);
    bus.go = 5'b00100; cyc(1);
    chk("s5b.step", 8'(bus.step), 8'd1);
    chk("s5b.dir",  8'(bus.dir),  8'd0);
    chk_head("s5b.mv", 4, 2);
    bus.go = 5'b00000; cyc(4);
    chk("s5b.dir2", 8'(bus.dir), 8'd2);
    chk_head("s5b.mv2", 3, 2);

    // Reversal judged against committed dir (left), not pending (up)
    bus.go = 5'b00001; cyc(1);
    bus.go = 5'b01000; cyc(1);
    bus.go = 5'b00000; cyc(2);
    chk("s5c.dir", 8'(bus.dir), 8'd0);
    chk_head("s5c.mv", 3, 1);
    cyc(4);
    chk("s5c.step", 8'(bus.step), 8'd1);
    chk_head("s5c.mv2", 3, 0);

    // Scenario 6: async reset between edges while step is high
    #2 rst_n = 1'b0;
    #1 chk_reset("s6.async");
    @(negedge clk) rst_n = 1'b1;
    cyc(2);
    chk_reset("s6.after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
